// File: rtl/cfg_mgmt_arb_pkg.sv
// Shared definitions for the configuration-management port arbiter:
// FSM state encoding, cfg address width and the timed-out read value.
`ifndef DLY
`define DLY
`endif

package cfg_mgmt_arb_pkg;

  localparam int          CFG_ADDR_W = 19;
  localparam logic [31:0] TMO_RDATA  = 32'hFFFF_FFFF;

  // One-hot state encoding
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_BUSY = 4'b0010;
  localparam logic [3:0] ST_RESP = 4'b0100;
  localparam logic [3:0] ST_GAP  = 4'b1000;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    RESP = ST_RESP,
    GAP  = ST_GAP
  } state_t;

endpackage

// File: rtl/cfg_mgmt_arb_if.sv
// PCIe core configuration-management bus. The arbiter is the master
// (drives address/strobes), the core is the slave (returns data/done).
interface cfg_mgmt_arb_if;
  import cfg_mgmt_arb_pkg::*;

  logic [CFG_ADDR_W-1:0] cfg_mgmt_addr_o;
  logic                  cfg_mgmt_write_o;
  logic [31:0]           cfg_mgmt_write_data_o;
  logic [3:0]            cfg_mgmt_byte_enable_o;
  logic                  cfg_mgmt_read_o;
  logic                  cfg_mgmt_type1_cfg_reg_access_o;
  logic [31:0]           cfg_mgmt_read_data_i;
  logic                  cfg_mgmt_read_write_done_i;

  modport master (
    output cfg_mgmt_addr_o, cfg_mgmt_write_o, cfg_mgmt_write_data_o,
           cfg_mgmt_byte_enable_o, cfg_mgmt_read_o, cfg_mgmt_type1_cfg_reg_access_o,
    input  cfg_mgmt_read_data_i, cfg_mgmt_read_write_done_i
  );

  modport slave (
    input  cfg_mgmt_addr_o, cfg_mgmt_write_o, cfg_mgmt_write_data_o,
           cfg_mgmt_byte_enable_o, cfg_mgmt_read_o, cfg_mgmt_type1_cfg_reg_access_o,
    output cfg_mgmt_read_data_i, cfg_mgmt_read_write_done_i
  );

endinterface

// File: rtl/cfg_mgmt_arb.sv
// Two-requester round-robin arbiter for the PCIe core cfg-management port.
// Holds the grant for one full access and bounds every access with a
// timeout so a hung core cannot lock up the requesters.
module cfg_mgmt_arb
  import cfg_mgmt_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMO_CNT_W   = 8
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst,

  input  logic [CFG_ADDR_W-1:0] req0_addr_i,
  input  logic                  req0_read_i,
  input  logic                  req0_write_i,
  input  logic [31:0]           req0_write_data_i,
  input  logic [3:0]            req0_byte_enable_i,
  input  logic                  req0_type1_i,
  output logic [31:0]           req0_read_data_o,
  output logic                  req0_done_o,
  output logic                  req0_tmo_o,

  input  logic [CFG_ADDR_W-1:0] req1_addr_i,
  input  logic                  req1_read_i,
  input  logic                  req1_write_i,
  input  logic [31:0]           req1_write_data_i,
  input  logic [3:0]            req1_byte_enable_i,
  input  logic                  req1_type1_i,
  output logic [31:0]           req1_read_data_o,
  output logic                  req1_done_o,
  output logic                  req1_tmo_o,

  cfg_mgmt_arb_if.master        cfg,

  output logic [TMO_CNT_W-1:0]  tmo_cnt_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t                r_state;
  logic                  r_gnt;      // requester owning the current access
  logic                  r_rr_ptr;   // requester preferred on a tie (the one not served last)
  logic [15:0]           r_tmo_ctr;
  logic [CFG_ADDR_W-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic                  r_type1;
  logic                  r_rd;
  logic                  r_wr;
  logic [31:0]           r_rdata;
  logic [1:0]            r_done;
  logic [1:0]            r_tmo;
  logic [TMO_CNT_W-1:0]  r_tmo_cnt;

  logic                  w_req0;
  logic                  w_req1;
  logic                  w_gnt_sel;
  logic                  w_gnt_req;
  logic [CFG_ADDR_W-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic [3:0]            w_sel_be;
  logic                  w_sel_type1;
  logic                  w_sel_rd;
  logic                  w_sel_wr;

  assign w_req0 = req0_read_i | req0_write_i;
  assign w_req1 = req1_read_i | req1_write_i;

  // Grant selection and request mux; only the selected requester is looked at
  always_comb begin
    w_gnt_sel = 1'b0;
    if (w_req0 && w_req1) begin
      w_gnt_sel = r_rr_ptr;
    end else if (w_req1) begin
      w_gnt_sel = 1'b1;
    end
    w_sel_addr  = w_gnt_sel ? req1_addr_i        : req0_addr_i;
    w_sel_wdata = w_gnt_sel ? req1_write_data_i  : req0_write_data_i;
    w_sel_be    = w_gnt_sel ? req1_byte_enable_i : req0_byte_enable_i;
    w_sel_type1 = w_gnt_sel ? req1_type1_i       : req0_type1_i;
    w_sel_rd    = w_gnt_sel ? req1_read_i        : req0_read_i;
    w_sel_wr    = w_gnt_sel ? req1_write_i       : req0_write_i;
    w_gnt_req   = r_gnt ? w_req1 : w_req0;
  end

  // Access FSM: grant, issue, wait for done/timeout/abort, respond, gap
  always_ff @(posedge usr_clk or posedge usr_rst) begin
    if (usr_rst) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b0;
      r_rr_ptr  <= 1'b0;
      r_tmo_ctr <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_type1   <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_rdata   <= '0;
      r_done    <= '0;
      r_tmo     <= '0;
      r_tmo_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            r_gnt     <= w_gnt_sel;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_be      <= w_sel_be;
            r_type1   <= w_sel_type1;
            // Write takes precedence when a requester raises both strobes
            r_wr      <= w_sel_wr;
            r_rd      <= w_sel_rd & ~w_sel_wr;
            r_tmo_ctr <= '0;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          r_tmo_ctr <= r_tmo_ctr + 16'd1;
          // Done beats both abort and the timeout terminal count
          if (cfg.cfg_mgmt_read_write_done_i) begin
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_rdata       <= cfg.cfg_mgmt_read_data_i;
            r_done[r_gnt] <= 1'b1;
            r_tmo[r_gnt]  <= 1'b0;
            r_state       <= RESP;
          end else if (!w_gnt_req) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= GAP;
          end else if (r_tmo_ctr == TMO_LAST) begin
            r_rd          <= 1'b0;
            r_wr          <= 1'b0;
            r_rdata       <= TMO_RDATA;
            r_done[r_gnt] <= 1'b1;
            r_tmo[r_gnt]  <= 1'b1;
            if (r_tmo_cnt != {TMO_CNT_W{1'b1}}) begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_state       <= RESP;
          end
        end
        RESP: begin
          r_done   <= '0;
          r_tmo    <= '0;
          r_rr_ptr <= ~r_gnt;
          r_state  <= GAP;
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cfg.cfg_mgmt_addr_o                 = r_addr;
  assign cfg.cfg_mgmt_write_o                = r_wr;
  assign cfg.cfg_mgmt_write_data_o           = r_wdata;
  assign cfg.cfg_mgmt_byte_enable_o          = r_be;
  assign cfg.cfg_mgmt_read_o                 = r_rd;
  assign cfg.cfg_mgmt_type1_cfg_reg_access_o = r_type1;

  assign req0_read_data_o = r_rdata;
  assign req0_done_o      = r_done[0];
  assign req0_tmo_o       = r_tmo[0];
  assign req1_read_data_o = r_rdata;
  assign req1_done_o      = r_done[1];
  assign req1_tmo_o       = r_tmo[1];
  assign tmo_cnt_o        = r_tmo_cnt;

endmodule

// File: doc/cfg_mgmt_arb.md
Name: cfg_mgmt_arb

Overview:
- Owns the PCIe core configuration-management port and shares it between two requesters.
- Requester 0 is the cfg register read/write self-test. Requester 1 is the host-side or debug config accessor.
- Arbitrates round-robin and holds the grant for one full access.
- Guards each access with a timeout, so a hung core never locks the SGDMA application.

Parameters:
- TIMEOUT_CYC, 1024: usr_clk cycles allowed between core strobe assertion and cfg_mgmt_read_write_done_i. Legal range 4..65535.
- TMO_CNT_W, 8: width of the saturating timeout event counter.

Ports:
- usr_clk  in  1  user clock; all logic on rising edge
- usr_rst  in  1  asynchronous, active-high reset
- reqN_addr_i  in  19  cfg address, N = 0,1 (one port per requester, same for every reqN line below)
- reqN_read_i  in  1  level read strobe, held until done or abort
- reqN_write_i  in  1  level write strobe, held until done or abort
- reqN_write_data_i  in  32  write data
- reqN_byte_enable_i  in  4  byte enables
- reqN_type1_i  in  1  type1 cfg register access
- reqN_read_data_o  out  32  read data, valid while reqN_done_o=1
- reqN_done_o  out  1  one-cycle completion pulse
- reqN_tmo_o  out  1  qualifies reqN_done_o: access timed out
- cfg_mgmt_addr_o  out  19  to core
- cfg_mgmt_write_o  out  1  to core
- cfg_mgmt_write_data_o  out  32  to core
- cfg_mgmt_byte_enable_o  out  4  to core
- cfg_mgmt_read_o  out  1  to core
- cfg_mgmt_type1_cfg_reg_access_o  out  1  to core
- cfg_mgmt_read_data_i  in  32  from core
- cfg_mgmt_read_write_done_i  in  1  from core
- tmo_cnt_o  out  TMO_CNT_W  saturating count of timed-out accesses

Behaviour:
- Reset value of every output is 0, including the round-robin pointer (which is 0, so requester 0 wins first) and tmo_cnt_o.
- States: IDLE, BUSY, RESP, GAP. Encoding is one-hot. Reset state is IDLE.
- IDLE, request detect:
  - A requester is "requesting" when read_i OR write_i is high.
  - If exactly one is requesting, grant it.
  - If both are requesting, grant the one that is not the last-granted requester.
- IDLE, latch and issue:
  - On grant, latch addr, wdata, byte_enable and type1 into core output registers.
  - Set cfg_mgmt_read_o or cfg_mgmt_write_o. If both read_i and write_i are high, perform the write and drive read low.
  - Go to BUSY.
  - Latency: requester strobe at edge k gives core strobe high from edge k+1.
- BUSY, completion:
  - Core outputs stay stable. The timeout counter increments each cycle.
  - When cfg_mgmt_read_write_done_i=1: clear the core strobe, capture cfg_mgmt_read_data_i (captured for writes too; don't-care), go to RESP.
- BUSY, timeout:
  - When the counter reaches TIMEOUT_CYC-1 without done: clear the core strobe and force read data to 32'hFFFF_FFFF.
  - Set tmo, increment tmo_cnt_o (saturating at all-ones), go to RESP.
  - If done and the timeout terminal count occur in the same cycle, done wins and there is no tmo.
- BUSY, abort:
  - If the granted requester drops both strobes, clear the core strobe next cycle and go to GAP.
  - No done pulse is issued. A core done arriving in the following cycle is ignored.
- RESP:
  - reqN_done_o=1 for exactly one cycle on the granted channel, with reqN_read_data_o and reqN_tmo_o valid.
  - Update the last-granted pointer, go to GAP.
  - The non-granted channel's done is never asserted.
- GAP:
  - One cycle in which no grant occurs. This lets the requester drop its level strobe after seeing done.
  - Then go to IDLE.
- Back-to-back accesses:
  - Minimum period per access is core latency + 3 cycles.
  - A requester that keeps its strobe high after GAP is treated as a new request.
- Reset mid-access: all outputs clear immediately (asynchronous), including the core strobes. A pending core done after reset release is ignored in IDLE.
- The waiting requester's inputs are not sampled until it is granted.

Decomposition:
- Shared package or header (alongside the existing parameter definitions) holds:
  - the state encoding localparams;
  - the 19-bit cfg address width constant;
  - the 32'hFFFF_FFFF timeout read value;
  - the existing `DLY macro.
- Keep one module, with no sub-module. The 2-way round-robin and timeout counter are too small to justify one.

Test Plan:
- Req0 read addr 0x3C; core returns done with data 0x0000_01FF after 5 cycles:
  - core read high for 5 cycles, addr=19'd60;
  - req0_done pulse 1 cycle with data 0x1FF, tmo=0;
  - req1_done stays 0.
- Req0 and req1 both assert read in the same cycle, both held:
  - grants follow req0, req1, req0;
  - done pulses alternate channels;
  - a GAP cycle separates core strobes.
- Core never asserts done, TIMEOUT_CYC=16:
  - core strobe drops after 16 BUSY cycles;
  - done pulse with tmo=1, data 0xFFFF_FFFF;
  - tmo_cnt_o increments to 1.
- Req1 write data 0xA5A5_0000, byte_enable 4'hF; drop strobe 2 cycles into BUSY:
  - core write clears next cycle;
  - no req1_done;
  - a later core done is ignored and the next request is served normally.
- Assert usr_rst during BUSY:
  - all cfg_mgmt outputs go 0 asynchronously;
  - after release, the first request is granted to req0.
- Req0 asserts both read and write:
  - core write issued, core read stays 0;
  - done pulses normally.
